ycbcr444_to_422: RTL and testbench



---
 rtl/ycbcr444_to_422.sv | 117 +++++++++++
 tb/tb_ycbcr444_to_422.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr444_to_422.sv
// 4:4:4 to 4:2:2 YCbCr chroma subsampler: pair-averaged (or co-sited) chroma,
// three-register pipeline with one-pixel lookahead, sync/de delayed alongside data.
module ycbcr444_to_422 #(
    parameter bit         AVG_EN  = 1'b1,
    parameter logic [7:0] BLANK_Y = 8'd16,
    parameter logic [7:0] BLANK_C = 8'd128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ycbcr_y,
    input  logic [7:0] ycbcr_cb,
    input  logic [7:0] ycbcr_cr,
    input  logic       ycbcr_hs,
    input  logic       ycbcr_vs,
    input  logic       ycbcr_de,
    output logic [7:0] yc_y,
    output logic [7:0] yc_c,
    output logic       yc_c_sel,
    output logic       yc_hs,
    output logic       yc_vs,
    output logic       yc_de
);

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       odd;
        logic       hs;
        logic       vs;
        logic       de;
    } stage_t;

    // Rounded mean of two 8-bit samples; the 9-bit sum cannot overflow.
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
    endfunction

    logic       phase_q, phase_d;
    stage_t     s1_q, s1_d;
    stage_t     s2_q;
    logic [7:0] hold_q, hold_d;
    logic [7:0] y_q, y_d;
    logic [7:0] c_q, c_d;
    logic       sel_q, sel_d;
    logic       hs_q, vs_q, de_q;
    logic       partner;

    always_comb begin
        phase_d   = ycbcr_de ? ~phase_q : 1'b0;
        s1_d.y    = ycbcr_y;
        s1_d.cb   = ycbcr_cb;
        s1_d.cr   = ycbcr_cr;
        s1_d.odd  = phase_q;
        s1_d.hs   = ycbcr_hs;
        s1_d.vs   = ycbcr_vs;
        s1_d.de   = ycbcr_de;
    end

    assign partner = s1_q.de && s1_q.odd;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        y_d    = BLANK_Y;
        c_d    = BLANK_C;
        sel_d  = 1'b0;
        hold_d = hold_q;
        if (s2_q.de) begin
            y_d = s2_q.y;
            if (s2_q.odd) begin
                c_d   = hold_q;
                sel_d = 1'b1;
            end else if (partner) begin
                c_d    = AVG_EN ? avg8(s2_q.cb, s1_q.cb) : s2_q.cb;
                hold_d = AVG_EN ? avg8(s2_q.cr, s1_q.cr) : s2_q.cr;
            end else begin
                // Lone even pixel at a run end: its Cr is never emitted.
                c_d = s2_q.cb;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            hold_q  <= '0;
            y_q     <= '0;
            c_q     <= '0;
            sel_q   <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            hold_q  <= hold_d;
            y_q     <= y_d;
            c_q     <= c_d;
            sel_q   <= sel_d;
            hs_q    <= s2_q.hs;
            vs_q    <= s2_q.vs;
            de_q    <= s2_q.de;
        end
    end

    assign yc_y     = y_q;
    assign yc_c     = c_q;
    assign yc_c_sel = sel_q;
    assign yc_hs    = hs_q;
    assign yc_vs    = vs_q;
    assign yc_de    = de_q;

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Scoreboard bench for ycbcr444_to_422: one averaging and one decimating instance
// driven in parallel, expected pixels queued at drive time and popped 3 cycles later.
module tb_ycbcr444_to_422;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_y, in_cb, in_cr;
    logic       in_hs, in_vs, in_de;

    logic [7:0] y_a, c_a, y_d, c_d;
    logic       sel_a, hs_a, vs_a, de_a, sel_d, hs_d, vs_d, de_d;

    always #5 clk = ~clk;

    ycbcr444_to_422 #(.AVG_EN(1'b1), .BLANK_Y(8'd16), .BLANK_C(8'd128)) u_avg (
        .clk(clk), .rst_n(rst_n),
        .ycbcr_y(in_y), .ycbcr_cb(in_cb), .ycbcr_cr(in_cr),
        .ycbcr_hs(in_hs), .ycbcr_vs(in_vs), .ycbcr_de(in_de),
        .yc_y(y_a), .yc_c(c_a), .yc_c_sel(sel_a),
        .yc_hs(hs_a), .yc_vs(vs_a), .yc_de(de_a)
    );

    ycbcr444_to_422 #(.AVG_EN(1'b0), .BLANK_Y(8'd16), .BLANK_C(8'd128)) u_dec (
        .clk(clk), .rst_n(rst_n),
        .ycbcr_y(in_y), .ycbcr_cb(in_cb), .ycbcr_cr(in_cr),
        .ycbcr_hs(in_hs), .ycbcr_vs(in_vs), .ycbcr_de(in_de),
        .yc_y(y_d), .yc_c(c_d), .yc_c_sel(sel_d),
        .yc_hs(hs_d), .yc_vs(vs_d), .yc_de(de_d)
    );

    typedef struct {
        logic [7:0] y, cb, cr;
        logic       hs, vs, de, ph;
    } pix_t;

    typedef struct {
        int         idx;
        logic [7:0] y, c_avg, c_dec;
        logic       sel, hs, vs, de;
    } exp_t;

    exp_t q[$];
    pix_t h1, h2;
    pix_t zero_pix;
    logic m_phase;
    int   cyc;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_avg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return s[7:0];
    endfunction

    task automatic drain();
        exp_t e;
        while (q.size() > 0 && q[0].idx < cyc - 2) void'(q.pop_front());
        if (q.size() > 0 && q[0].idx == cyc - 2) begin
            e = q.pop_front();
            check("y_avg",   y_a,   e.y);
            check("y_dec",   y_d,   e.y);
            check("c_avg",   c_a,   e.c_avg);
            check("c_dec",   c_d,   e.c_dec);
            check("sel_avg", sel_a, e.sel);
            check("sel_dec", sel_d, e.sel);
            check("hs",      hs_a,  e.hs);
            check("vs",      vs_d,  e.vs);
            check("de_avg",  de_a,  e.de);
            check("de_dec",  de_d,  e.de);
        end
    endtask

    task automatic step(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic hs, input logic vs, input logic de);
        pix_t cur;
        exp_t e;
        cur.y = y; cur.cb = cb; cur.cr = cr;
        cur.hs = hs; cur.vs = vs; cur.de = de; cur.ph = m_phase;
        m_phase = de ? ~m_phase : 1'b0;
        in_y = y; in_cb = cb; in_cr = cr; in_hs = hs; in_vs = vs; in_de = de;

        e.idx = cyc;
        e.hs = h1.hs; e.vs = h1.vs; e.de = h1.de;
        if (!h1.de) begin
            e.y = 8'd16; e.c_avg = 8'd128; e.c_dec = 8'd128; e.sel = 1'b0;
        end else if (!h1.ph) begin
            e.y = h1.y; e.sel = 1'b0;
            e.c_avg = cur.de ? ref_avg(h1.cb, cur.cb) : h1.cb;
            e.c_dec = h1.cb;
        end else begin
            e.y = h1.y; e.sel = 1'b1;
            e.c_avg = ref_avg(h2.cr, h1.cr);
            e.c_dec = h2.cr;
        end
        q.push_back(e);
        h2 = h1;
        h1 = cur;

        @(posedge clk);
        cyc++;
        #1;
        drain();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_y"},   {y_a, y_d},     16'd0);
        check({tag, "_c"},   {c_a, c_d},     16'd0);
        check({tag, "_sel"}, {sel_a, sel_d}, 2'd0);
        check({tag, "_hs"},  {hs_a, hs_d},   2'd0);
        check({tag, "_vs"},  {vs_a, vs_d},   2'd0);
        check({tag, "_de"},  {de_a, de_d},   2'd0);
    endtask

    // Called #1 after a rising edge; asserts reset between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        in_y = '0; in_cb = '0; in_cr = '0; in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
        #1;
        check_zero("rst_now");
        q.delete();
        h1 = zero_pix;
        h2 = zero_pix;
        m_phase = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        check_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_phase = 1'b0;
        zero_pix = '{y: 8'd0, cb: 8'd0, cr: 8'd0, hs: 1'b0, vs: 1'b0, de: 1'b0, ph: 1'b0};
        h1 = zero_pix;
        h2 = zero_pix;
        rst_n = 1'b1;
        in_y = '0; in_cb = '0; in_cr = '0; in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
        @(posedge clk);
        cyc++;
        #1;

        // Reset and blanking
        do_reset();
        idle(5);

        // 4-pixel run
        step(8'd10, 8'd100, 8'd200, 1'b0, 1'b0, 1'b1);
        step(8'd20, 8'd101, 8'd202, 1'b0, 1'b0, 1'b1);
        step(8'd30, 8'd50,  8'd0,   1'b0, 1'b0, 1'b1);
        step(8'd40, 8'd60,  8'd255, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Odd run of 3
        step(8'd10, 8'd100, 8'd200, 1'b0, 1'b0, 1'b1);
        step(8'd20, 8'd101, 8'd202, 1'b0, 1'b0, 1'b1);
        step(8'd30, 8'd77,  8'd33,  1'b0, 1'b0, 1'b1);
        idle(3);

        // Single-cycle de gap restarts pairing
        step(8'd1, 8'd11, 8'd21, 1'b0, 1'b0, 1'b1);
        step(8'd2, 8'd12, 8'd22, 1'b0, 1'b0, 1'b1);
        step(8'd9, 8'd99, 8'd99, 1'b0, 1'b0, 1'b0);
        step(8'd3, 8'd13, 8'd23, 1'b0, 1'b0, 1'b1);
        step(8'd4, 8'd14, 8'd24, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Sync pulses, one during blanking and one on a data pixel
        step(8'd0,  8'd0,  8'd0,  1'b1, 1'b0, 1'b0);
        idle(2);
        step(8'd50, 8'd60, 8'd70, 1'b0, 1'b1, 1'b1);
        step(8'd51, 8'd61, 8'd71, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Mid-line reset discards in-flight pixels
        step(8'd80, 8'd90, 8'd100, 1'b0, 1'b0, 1'b1);
        step(8'd81, 8'd91, 8'd101, 1'b0, 1'b0, 1'b1);
        step(8'd82, 8'd92, 8'd102, 1'b0, 1'b0, 1'b1);
        do_reset();
        step(8'd83, 8'd93, 8'd103, 1'b0, 1'b0, 1'b1);
        step(8'd84, 8'd94, 8'd104, 1'b0, 1'b0, 1'b1);
        step(8'd85, 8'd95, 8'd105, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Random runs with random gaps and sync
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 4) != 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
